// File: rtl/dma_burst_engine.sv
// APB-programmed burst DMA: copies SIZE words between the two memory banks through
// a small FIFO, overlapping source reads and destination writes once the FIFO fills.
module dma_burst_engine #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int SIZE_WIDTH   = 16,
    parameter int BANK_SEL_BIT = 20
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  INTR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  mem0_en,
    output logic [3:0]            mem0_we,
    output logic [ADDR_WIDTH-1:0] mem0_addr,
    output logic [DATA_WIDTH-1:0] mem0_wdata,
    input  logic [DATA_WIDTH-1:0] mem0_rdata,
    output logic                  mem1_en,
    output logic [3:0]            mem1_we,
    output logic [ADDR_WIDTH-1:0] mem1_addr,
    output logic [DATA_WIDTH-1:0] mem1_wdata,
    input  logic [DATA_WIDTH-1:0] mem1_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] A_SRC  = ADDR_WIDTH'(32'h00);
    localparam logic [ADDR_WIDTH-1:0] A_DST  = ADDR_WIDTH'(32'h04);
    localparam logic [ADDR_WIDTH-1:0] A_SIZE = ADDR_WIDTH'(32'h08);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(32'h0C);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(32'h10);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] src, dst;
    logic [SIZE_WIDTH-1:0] size;
    logic                  ie, done, err;
    logic [SIZE_WIDTH-1:0] rd_cnt, wr_cnt;
    logic                  rd_vld;

    logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic apb_wr, apb_rd, busy, start, same_bank, running, room, rd_fire, wr_fire, src_mem0;
    logic [15:0]           rd_word, wr_word;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [DATA_WIDTH-1:0] rdata, head;

    assign PREADY    = PSEL & PENABLE;
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & PENABLE & ~PWRITE;
    assign busy      = (state != IDLE);
    assign start     = apb_wr && (PADDR == A_CTRL) && PWDATA[0] && !busy;
    assign same_bank = (src[BANK_SEL_BIT] == dst[BANK_SEL_BIT]);
    assign src_mem0  = src[BANK_SEL_BIT];
    assign running   = (state == RUN);

    // A read in flight already owns a FIFO slot, so it counts against the space.
    assign room    = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(rd_vld)) < (CNT_W+1)'(FIFO_DEPTH);
    assign rd_fire = running && (rd_cnt < size) && room;
    assign wr_fire = running && (fifo_count != '0);

    assign rd_word = src[17:2] + 16'(rd_cnt);
    assign wr_word = dst[17:2] + 16'(wr_cnt);
    assign rd_addr = ADDR_WIDTH'(rd_word);
    assign wr_addr = ADDR_WIDTH'(wr_word);
    assign head    = fifo[rd_ptr];
    assign rdata   = src_mem0 ? mem0_rdata : mem1_rdata;

    assign mem0_en    = src_mem0 ? rd_fire : wr_fire;
    assign mem1_en    = src_mem0 ? wr_fire : rd_fire;
    assign mem0_we    = (!src_mem0 && wr_fire) ? 4'hF : 4'h0;
    assign mem1_we    = ( src_mem0 && wr_fire) ? 4'hF : 4'h0;
    assign mem0_addr  = mem0_en ? (src_mem0 ? rd_addr : wr_addr) : '0;
    assign mem1_addr  = mem1_en ? (src_mem0 ? wr_addr : rd_addr) : '0;
    assign mem0_wdata = (!src_mem0 && wr_fire) ? head : '0;
    assign mem1_wdata = ( src_mem0 && wr_fire) ? head : '0;

    always_comb begin
        PRDATA = '0;
        if (apb_rd) begin
            case (PADDR)
                A_SRC:   PRDATA = DATA_WIDTH'(src);
                A_DST:   PRDATA = DATA_WIDTH'(dst);
                A_SIZE:  PRDATA = DATA_WIDTH'(size);
                A_CTRL:  PRDATA = DATA_WIDTH'({ie, 1'b0});
                A_STAT:  PRDATA = DATA_WIDTH'({err, busy, done});
                default: PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            size       <= '0;
            ie         <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            INTR       <= 1'b0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_vld     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (apb_wr) begin
                if (PADDR == A_SRC  && !busy) src  <= ADDR_WIDTH'(PWDATA);
                if (PADDR == A_DST  && !busy) dst  <= ADDR_WIDTH'(PWDATA);
                if (PADDR == A_SIZE && !busy) size <= SIZE_WIDTH'(PWDATA);
                if (PADDR == A_CTRL)          ie   <= PWDATA[1];
                if (PADDR == A_STAT) begin
                    if (PWDATA[0]) done <= 1'b0;
                    if (PWDATA[2]) err  <= 1'b0;
                end
            end
            // Hardware sets come after the W1C so they win on a collision.
            if (state == FINISH)      done <= 1'b1;
            if (start && same_bank)   err  <= 1'b1;

            INTR   <= done & ie;
            rd_vld <= rd_fire;

            case (state)
                IDLE: begin
                    if (start) begin
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        state  <= (size == '0 || same_bank) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt + 1'b1 == size) state <= FINISH;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (rd_vld)  wr_ptr <= wr_ptr + 1'b1;
            if (wr_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({rd_vld, wr_fire})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rd_vld) fifo[wr_ptr] <= rdata;
    end
endmodule

// File: tb/tb_dma_burst_engine.sv
// Bench for dma_burst_engine: scoreboard queues hold expected memory writes and APB
// read data; a negedge monitor pops and compares whenever the DUT presents one.
module tb_dma_burst_engine;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        INTR, PSEL = 0, PENABLE = 0, PWRITE = 0, PREADY;
    logic [31:0] PADDR = 0, PWDATA = 0, PRDATA;
    logic        mem0_en, mem1_en;
    logic [3:0]  mem0_we, mem1_we;
    logic [31:0] mem0_addr, mem1_addr, mem0_wdata, mem1_wdata;
    logic [31:0] mem0_rdata = 0, mem1_rdata = 0;

    dma_burst_engine dut (
        .CLK(CLK), .RST(RST), .INTR(INTR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA),
        .mem0_en(mem0_en), .mem0_we(mem0_we), .mem0_addr(mem0_addr),
        .mem0_wdata(mem0_wdata), .mem0_rdata(mem0_rdata),
        .mem1_en(mem1_en), .mem1_we(mem1_we), .mem1_addr(mem1_addr),
        .mem1_wdata(mem1_wdata), .mem1_rdata(mem1_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        bank;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int n_rd0 = 0, n_rd1 = 0, n_wr0 = 0, n_wr1 = 0, n_rd = 0, n_wr = 0;
    int rd_cyc [0:255];
    int wr_cyc [0:255];

    function automatic logic [31:0] init0(int a); return 32'hA000_0000 + a; endfunction
    function automatic logic [31:0] init1(int a); return 32'hB000_0000 + a; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: unwritten words return a fixed pattern of their address.
    bit [31:0] m0 [0:4095];
    bit [31:0] m1 [0:4095];
    bit        v0 [0:4095];
    bit        v1 [0:4095];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem0_en) begin
            if (mem0_we == 4'hF) begin m0[mem0_addr[11:0]] <= mem0_wdata; v0[mem0_addr[11:0]] <= 1'b1; end
            else mem0_rdata <= v0[mem0_addr[11:0]] ? m0[mem0_addr[11:0]] : init0(int'(mem0_addr[11:0]));
        end
        if (mem1_en) begin
            if (mem1_we == 4'hF) begin m1[mem1_addr[11:0]] <= mem1_wdata; v1[mem1_addr[11:0]] <= 1'b1; end
            else mem1_rdata <= v1[mem1_addr[11:0]] ? m1[mem1_addr[11:0]] : init1(int'(mem1_addr[11:0]));
        end
    end

    task automatic mon_wr(input logic bank, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we);
        wr_t e;
        chk("mem_we", {28'h0, we}, 32'hF);
        if (exp_wr_q.size() == 0) begin
            chk("unexpected_write", {31'h0, bank}, 32'hFFFF_FFFF);
        end else begin
            e = exp_wr_q.pop_front();
            chk("wr_bank", {31'h0, bank}, {31'h0, e.bank});
            chk("wr_addr", a, e.addr);
            chk("wr_data", d, e.data);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (mem0_en && mem0_we == 4'h0) begin rd_cyc[n_rd[7:0]] = cyc; n_rd++; n_rd0++; end
            if (mem1_en && mem1_we == 4'h0) begin rd_cyc[n_rd[7:0]] = cyc; n_rd++; n_rd1++; end
            if (mem0_en && mem0_we != 4'h0) begin
                wr_cyc[n_wr[7:0]] = cyc; n_wr++; n_wr0++;
                mon_wr(1'b0, mem0_addr, mem0_wdata, mem0_we);
            end
            if (mem1_en && mem1_we != 4'h0) begin
                wr_cyc[n_wr[7:0]] = cyc; n_wr++; n_wr1++;
                mon_wr(1'b1, mem1_addr, mem1_wdata, mem1_we);
            end
            if (PSEL && PENABLE && !PWRITE) begin
                chk("pready", {31'h0, PREADY}, 32'h1);
                if (exp_rd_q.size() == 0) chk("unexpected_read", PRDATA, 32'hFFFF_FFFF);
                else chk("apb_rdata", PRDATA, exp_rd_q.pop_front());
            end
        end
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge CLK); #1;
        PENABLE = 1;
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        @(posedge CLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge CLK); #1;
        PENABLE = 1;
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic wait_intr(input int budget, input string name);
        int n = 0;
        while (!INTR && n < budget) begin @(negedge CLK); n++; end
        chk(name, {31'h0, INTR}, 32'h1);
    endtask

    task automatic push_copy(input logic bank, input int dword, input int sword, input int n);
        for (int i = 0; i < n; i++)
            exp_wr_q.push_back('{bank: bank, addr: 32'(dword + i),
                                 data: bank ? init0(sword + i) : init1(sword + i)});
    endtask

    initial begin
        int br, bw, r0, r1, w0, w1, n;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_intr", {31'h0, INTR}, 0);
        chk("rst_en", {30'h0, mem0_en, mem1_en}, 0);
        chk("rst_we_addr", {mem0_we, mem1_we, mem0_addr[11:0], mem1_addr[11:0]}, 0);
        chk("rst_pready", {31'h0, PREADY}, 0);
        chk("rst_prdata", PRDATA, 0);
        @(posedge CLK); #1 RST = 0;
        apb_read(32'h00, 0); apb_read(32'h08, 0); apb_read(32'h10, 0);

        // Basic copy mem0 -> mem1
        apb_write(32'h00, 32'h0010_0000);
        apb_write(32'h04, 32'h0000_0040);
        apb_write(32'h08, 8);
        apb_write(32'h14, 32'hDEAD);
        apb_read(32'h14, 0);
        apb_read(32'h08, 8);
        push_copy(1'b1, 32'h10, 0, 8);
        br = n_rd; bw = n_wr; r0 = n_rd0; w1 = n_wr1; r1 = n_rd1; w0 = n_wr0;
        apb_write(32'h0C, 32'h3);
        wait_intr(100, "basic_intr");
        chk("basic_reads", n_rd0 - r0, 8);
        chk("basic_writes", n_wr1 - w1, 8);
        chk("basic_other", (n_rd1 - r1) + (n_wr0 - w0), 0);
        chk("basic_first_lat", wr_cyc[bw[7:0]] - rd_cyc[br[7:0]], 2);
        chk("basic_last_lat", wr_cyc[(bw + 7) & 255] - rd_cyc[br[7:0]], 9);
        for (int i = 0; i < 8; i++) chk("basic_mem1", m1[16 + i], init0(i));
        apb_read(32'h10, 32'h1);
        apb_write(32'h10, 32'h1);
        repeat (2) @(negedge CLK);
        chk("basic_intr_clr", {31'h0, INTR}, 0);

        // Reverse direction, SIZE larger than FIFO
        apb_write(32'h00, 32'h0000_0100);
        apb_write(32'h04, 32'h0010_0200);
        apb_write(32'h08, 20);
        push_copy(1'b0, 32'h80, 32'h40, 20);
        br = n_rd; bw = n_wr; r1 = n_rd1; w0 = n_wr0;
        apb_write(32'h0C, 32'h3);
        wait_intr(200, "rev_intr");
        chk("rev_reads", n_rd1 - r1, 20);
        chk("rev_writes", n_wr0 - w0, 20);
        chk("rev_last_lat", wr_cyc[(bw + 19) & 255] - rd_cyc[br[7:0]], 21);
        apb_write(32'h10, 32'h1);

        // SIZE = 0
        apb_write(32'h08, 0);
        n = n_rd + n_wr;
        apb_write(32'h0C, 32'h3);
        apb_read(32'h10, 32'h1);
        chk("size0_intr", {31'h0, INTR}, 1);
        chk("size0_noaccess", n_rd + n_wr - n, 0);
        apb_write(32'h10, 32'h1);
        repeat (2) @(negedge CLK);
        chk("size0_intr_clr", {31'h0, INTR}, 0);

        // Same-bank error
        apb_write(32'h00, 32'h0010_0000);
        apb_write(32'h04, 32'h0010_0100);
        apb_write(32'h08, 4);
        n = n_rd + n_wr;
        apb_write(32'h0C, 32'h3);
        apb_read(32'h10, 32'h5);
        chk("err_intr", {31'h0, INTR}, 1);
        chk("err_noaccess", n_rd + n_wr - n, 0);
        apb_write(32'h10, 32'h5);
        apb_read(32'h10, 32'h0);
        chk("err_intr_clr", {31'h0, INTR}, 0);

        // Busy protection
        apb_write(32'h00, 32'h0010_0400);
        apb_write(32'h04, 32'h0000_0800);
        apb_write(32'h08, 16);
        push_copy(1'b1, 32'h200, 32'h100, 16);
        w1 = n_wr1;
        apb_write(32'h0C, 32'h3);
        apb_read(32'h10, 32'h2);
        apb_write(32'h08, 2);
        apb_write(32'h0C, 32'h3);
        wait_intr(200, "busy_intr");
        chk("busy_writes", n_wr1 - w1, 16);
        apb_read(32'h08, 16);
        apb_read(32'h10, 32'h1);
        apb_write(32'h10, 32'h1);

        // Reset mid-transfer
        apb_write(32'h04, 32'h0000_0C00);
        apb_write(32'h00, 32'h0010_0000);
        push_copy(1'b1, 32'h300, 0, 16);
        w1 = n_wr1;
        apb_write(32'h0C, 32'h3);
        n = 0;
        while ((n_wr1 - w1) < 5 && n < 200) begin @(negedge CLK); n++; end
        chk("mid_reached_word5", {31'h0, (n_wr1 - w1) >= 5}, 1);
        RST = 1;
        @(posedge CLK); #1 RST = 0;
        exp_wr_q.delete();
        @(negedge CLK);
        chk("mid_en", {30'h0, mem0_en, mem1_en}, 0);
        chk("mid_intr", {31'h0, INTR}, 0);
        n = n_rd + n_wr;
        repeat (6) @(negedge CLK);
        chk("mid_quiet", n_rd + n_wr - n, 0);
        apb_read(32'h00, 0); apb_read(32'h04, 0); apb_read(32'h08, 0);
        apb_read(32'h0C, 0); apb_read(32'h10, 0);

        repeat (2) @(negedge CLK);
        chk("wr_q_empty", exp_wr_q.size(), 0);
        chk("rd_q_empty", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dma_burst_engine.md
Name: dma_burst_engine

Overview:
- Parametrised successor to the single-word APB DMA.
- Copies SIZE consecutive words from one memory bank to the other through an internal FIFO, keeping reads and writes overlapped for one word per cycle after fill.
- Sits between the APB host interface and the two single-port memory banks. Raises INTR on completion.

Parameters:
- ADDR_WIDTH, 32, APB address, register and memory address width.
- DATA_WIDTH, 32, APB and memory data width.
- FIFO_DEPTH, 4, internal FIFO entries (power of 2, ≥2).
- SIZE_WIDTH, 16, usable bits of the SIZE register (word count).
- BANK_SEL_BIT, 20, address bit selecting the bank (1 = mem0, 0 = mem1).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- INTR  out  1  interrupt, registered
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  ADDR_WIDTH  APB address
- PWDATA  in  DATA_WIDTH  APB write data
- PREADY  out  1  APB ready
- PRDATA  out  DATA_WIDTH  APB read data
- memN_en  out  1  memory enable (N = 0, 1)
- memN_we  out  4  byte write enables
- memN_addr  out  ADDR_WIDTH  word address
- memN_wdata  out  DATA_WIDTH  write data
- memN_rdata  in  DATA_WIDTH  read data, valid 1 cycle after an en with we = 0

Behaviour:
- Reset: one clock, synchronous, active-high (RST sampled on rising CLK).
  - All registers, FIFO pointers and counters go to 0; state goes to IDLE.
  - INTR = 0, PREADY = 0, PRDATA = 0, all memN_en/we/addr/wdata = 0.
  - RST asserted mid-transfer aborts the transfer immediately; no further memory accesses occur.
- APB interface:
  - Zero wait states: PREADY = 1 in every cycle with PSEL & PENABLE, otherwise 0.
  - Writes take effect at the end of the access cycle.
  - PRDATA is driven during read access cycles and is 0 otherwise.
  - Unmapped addresses read as 0; writes to them are ignored. Registers are never cleared on a bad address.
- Register map:
  - 0x00 SRC: byte address, R/W.
  - 0x04 DST: byte address, R/W.
  - 0x08 SIZE: word count, R/W, upper bits beyond SIZE_WIDTH read 0.
  - 0x0C CTRL: bit0 START (write-1 pulse, reads 0); bit1 IE (R/W).
  - 0x10 STATUS: bit0 DONE (W1C); bit1 BUSY (RO); bit2 ERR (W1C).
- Writes while busy: writes to SRC, DST or SIZE while BUSY = 1 are ignored. START while BUSY = 1 is ignored.
- Address generation:
  - Word address = {SRC or DST}[17:2] + word index, zero-extended to ADDR_WIDTH.
  - The 16-bit index wraps modulo 2^16.
- FSM states: IDLE, RUN, FINISH.
  - IDLE → FINISH if START with SIZE = 0, or if SRC[BANK_SEL_BIT] == DST[BANK_SEL_BIT]. The equal-bank case sets ERR and makes no memory access.
  - IDLE → RUN on any other START. Latch counters; BUSY = 1.
  - RUN, read side:
    - Issue a read (src en = 1, we = 0) when rd_cnt < SIZE and fifo_count + rd_inflight < FIFO_DEPTH.
    - Read data is pushed into the FIFO the following cycle.
  - RUN, write side:
    - Issue a write (dst en = 1, we = 4'b1111, wdata = FIFO head) when the FIFO is non-empty; pop in the same cycle.
    - Push and pop in the same cycle are legal; the count is unchanged.
  - RUN → FINISH when wr_cnt reaches SIZE.
  - FINISH → IDLE after 1 cycle. Sets DONE, clears BUSY.
- Throughput: for SIZE = N ≥ 1 and no back-pressure, the first write occurs 2 cycles after the first read. The last write occurs N + 1 cycles after the first read. DONE is set 2 cycles after the last write.
- Memory ports: only the source bank reads and only the destination bank writes. All en/we outputs are 0 outside RUN.
- INTR: registered, equal to DONE & IE. Clears the cycle after DONE is cleared or IE = 0.
- Simultaneous events: if the hardware sets DONE or ERR in the same cycle software clears it via W1C, the set wins.

Test Plan:
- Basic copy: SRC = 0x0010_0000 (mem0), DST = 0x0000_0040 (mem1), SIZE = 8, IE = 1, START.
  - mem1 words 0x10–0x17 equal mem0 words 0x00–0x07.
  - Exactly 8 reads and 8 writes; INTR rises; BUSY falls.
- Reverse direction with FIFO_DEPTH = 4: SRC in mem1, DST in mem0, SIZE = 20.
  - FIFO never overflows; steady state is 1 word per cycle; data intact.
- SIZE = 0: START leads to DONE = 1 within 2 cycles.
  - No memN_en pulses; INTR = 1 if IE = 1.
- Same-bank error: SRC = 0x0010_0000, DST = 0x0010_0100, START.
  - ERR = 1, DONE = 1, no memory access.
  - Writing STATUS = 0x5 clears both; INTR drops the next cycle.
- Busy protection: during a SIZE = 16 transfer, write SIZE = 2 and issue START.
  - Both are ignored; 16 words are copied; SIZE reads back 16.
- Reset mid-transfer: assert RST at word 5 of 16.
  - Next cycle all memN_en = 0, BUSY = 0, INTR = 0, registers read 0.
